// File: rtl/bit_counter_pkg.sv
// Shared types for the bit-statistics engine: count modes, FSM states, result-width helper.
// Pure declarations, no logic.
// No flow control of its own.
package bit_counter_pkg;

    typedef enum logic [1:0] {
        MODE_ONES  = 2'b00,
        MODE_ZEROS = 2'b01,
        MODE_LZ    = 2'b10,
        MODE_TZ    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Width needed to hold any count from 0 to n inclusive.
    function automatic int bc_rw(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bit_counter_chunk.sv
// K-bit chunk statistics: popcount, index of lowest set bit, and a found flag.
// Purely combinational, zero latency.
// No flow control; evaluated every cycle on the current chunk.
module bit_counter_chunk #(
    parameter int K  = 1,
    parameter int CW = $clog2(K + 1)
) (
    input  logic [K-1:0]  chunk,
    output logic [CW-1:0] pop,
    output logic [CW-1:0] low_idx,
    output logic          found
);

    always_comb begin
        pop     = '0;
        low_idx = '0;
        found   = 1'b0;
        // Walk downward so the lowest set bit is the last one written.
        for (int i = K - 1; i >= 0; i--) begin
            pop = pop + CW'(chunk[i]);
            if (chunk[i]) begin
                found   = 1'b1;
                low_idx = CW'(i);
            end
        end
    end

endmodule

// File: rtl/bit_counter.sv
// Multi-cycle ones/zeros/leading-zero/trailing-zero counter, K bits per cycle; optional parity via BIT_COUNTER_PARITY_EN.
// Latency: R RUN cycles from accept to out_valid (early exit for ones/lz/tz), one operand per R+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; clear aborts from any state.
module bit_counter
    import bit_counter_pkg::*;
#(
    parameter int  N  = 8,
    parameter int  K  = 1,
    localparam int RW = bc_rw(N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  A,
    input  logic [1:0]    mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] result,
    output logic          busy
`ifdef BIT_COUNTER_PARITY_EN
    ,
    output logic          parity
`endif
);

    localparam int NCHUNK = N / K;
    localparam int CW     = $clog2(K + 1);
    localparam int CNTW   = $clog2(NCHUNK + 1);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NCHUNK - 1);

    if ((K < 1) || (K > N) || ((N % K) != 0)) begin : g_cfg_check
        $error("bit_counter: K must be in 1..N and divide N");
    end

    state_e          state_q, state_d;
    mode_e           mode_q, mode_d;
    logic [N-1:0]    shift_q, shift_d;
    logic [N-1:0]    shift_next;
    logic [N-1:0]    a_rev;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [RW-1:0]   result_q, result_d;
    logic [CW-1:0]   chunk_pop;
    logic [CW-1:0]   chunk_low;
    logic            chunk_found;
    logic            last_chunk;
    logic            accept;

    bit_counter_chunk #(
        .K  (K),
        .CW (CW)
    ) u_chunk (
        .chunk   (shift_q[K-1:0]),
        .pop     (chunk_pop),
        .low_idx (chunk_low),
        .found   (chunk_found)
    );

    // Leading-zero count is a trailing-zero count on the mirrored operand.
    always_comb begin
        a_rev = '0;
        for (int i = 0; i < N; i++) begin
            a_rev[i] = A[N-1-i];
        end
    end

    assign shift_next = shift_q >> K;
    assign last_chunk = (cnt_q == LAST_CNT);
    assign accept     = (state_q == ST_IDLE) && in_valid;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (clear) begin
            state_d  = ST_IDLE;
            result_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        mode_d   = mode_e'(mode);
                        shift_d  = (mode_e'(mode) == MODE_LZ) ? a_rev : A;
                        cnt_d    = '0;
                        result_d = '0;
                        state_d  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    shift_d = shift_next;
                    cnt_d   = cnt_q + CNTW'(1);
                    case (mode_q)
                        MODE_ONES: begin
                            result_d = result_q + RW'(chunk_pop);
                            if ((shift_next == '0) || last_chunk) begin
                                state_d = ST_DONE;
                            end
                        end
                        MODE_ZEROS: begin
                            result_d = result_q + RW'(K) - RW'(chunk_pop);
                            if (last_chunk) begin
                                state_d = ST_DONE;
                            end
                        end
                        default: begin
                            if (chunk_found) begin
                                result_d = result_q + RW'(chunk_low);
                                state_d  = ST_DONE;
                            end else begin
                                result_d = result_q + RW'(K);
                                if (last_chunk) begin
                                    state_d = ST_DONE;
                                end
                            end
                        end
                    endcase
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_ONES;
            shift_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN);
    assign result    = result_q;

`ifdef BIT_COUNTER_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (clear) begin
            parity_d = 1'b0;
        end else if (accept) begin
            parity_d = ^A;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
`endif

endmodule

// File: tb/tb_bit_counter.sv
// Bench for bit_counter: two instances (K=1 and K=2, N=8) checked against an arithmetic model.
module tb_bit_counter;

    localparam int N  = 8;
    localparam int RW = 4;

    logic          clk;
    logic          reset_n;
    logic          clear     [2];
    logic          in_valid  [2];
    logic          in_ready  [2];
    logic [N-1:0]  a_in      [2];
    logic [1:0]    mode_in   [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [RW-1:0] res       [2];
    logic          busy      [2];
`ifdef BIT_COUNTER_PARITY_EN
    logic          parity    [2];
`endif

    int tests_run;
    int tests_failed;

    bit_counter #(.N(N), .K(1)) u_dut_k1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear[0]),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .A         (a_in[0]),
        .mode      (mode_in[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .result    (res[0]),
        .busy      (busy[0])
`ifdef BIT_COUNTER_PARITY_EN
        ,
        .parity    (parity[0])
`endif
    );

    bit_counter #(.N(N), .K(2)) u_dut_k2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear[1]),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .A         (a_in[1]),
        .mode      (mode_in[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .result    (res[1]),
        .busy      (busy[1])
`ifdef BIT_COUNTER_PARITY_EN
        ,
        .parity    (parity[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int k_of(input int u);
        return (u == 0) ? 1 : 2;
    endfunction

    function automatic int highest_set(input logic [N-1:0] a);
        int h = -1;
        for (int i = 0; i < N; i++) if (a[i]) h = i;
        return h;
    endfunction

    function automatic int lowest_set(input logic [N-1:0] a);
        int l = -1;
        for (int i = N - 1; i >= 0; i--) if (a[i]) l = i;
        return l;
    endfunction

    function automatic int ceil_div(input int x, input int k);
        return (x + k - 1) / k;
    endfunction

    function automatic int model_result(input logic [N-1:0] a, input logic [1:0] m);
        case (m)
            2'b00:   return $countones(a);
            2'b01:   return N - $countones(a);
            2'b10:   return (a == 0) ? N : N - 1 - highest_set(a);
            default: return (a == 0) ? N : lowest_set(a);
        endcase
    endfunction

    function automatic int model_cycles(input logic [N-1:0] a, input logic [1:0] m, input int k);
        case (m)
            2'b00:   return (a == 0) ? 1 : ceil_div(highest_set(a) + 1, k);
            2'b01:   return N / k;
            2'b10:   return (a == 0) ? N / k : ceil_div(N - highest_set(a), k);
            default: return (a == 0) ? N / k : ceil_div(lowest_set(a) + 1, k);
        endcase
    endfunction

    task automatic run_op(input int u, input logic [N-1:0] a, input logic [1:0] m,
                          input int hold, input string tag);
        int exp_res;
        int exp_cyc;
        int cyc;
        bit seen;
        bit stable;
        exp_res = model_result(a, m);
        exp_cyc = model_cycles(a, m, k_of(u));
        @(negedge clk);
        tests_run++;
        if (in_ready[u] !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s in_ready before accept: got %b want 1", tag, in_ready[u]);
        end
        in_valid[u] = 1'b1;
        a_in[u]     = a;
        mode_in[u]  = m;
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
        a_in[u]     = N'($urandom);
        mode_in[u]  = 2'($urandom_range(0, 3));
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            if (out_valid[u] === 1'b1) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        tests_run++;
        if (!seen || cyc != exp_cyc) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d cycles (seen=%0b) want %0d", tag, cyc, seen, exp_cyc);
        end
        tests_run++;
        if (res[u] !== RW'(exp_res)) begin
            tests_failed++;
            $display("FAIL %s result: got %0d want %0d (A=%h mode=%0d)", tag, res[u], exp_res, a, m);
        end
`ifdef BIT_COUNTER_PARITY_EN
        tests_run++;
        if (parity[u] !== ^a) begin
            tests_failed++;
            $display("FAIL %s parity: got %b want %b", tag, parity[u], ^a);
        end
`endif
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (out_valid[u] !== 1'b1 || res[u] !== RW'(exp_res) || in_ready[u] !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) begin
            tests_run++;
            if (!stable) begin
                tests_failed++;
                $display("FAIL %s hold: outputs moved while out_ready low (got ov=%b res=%0d rdy=%b) want 1/%0d/0",
                         tag, out_valid[u], res[u], in_ready[u], exp_res);
            end
        end
        @(negedge clk);
        out_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[u] = 1'b0;
        tests_run++;
        if (out_valid[u] !== 1'b0 || in_ready[u] !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s release: got out_valid=%b in_ready=%b want 0/1", tag, out_valid[u], in_ready[u]);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            clear[u] = 1'b0; in_valid[u] = 1'b0; out_ready[u] = 1'b0;
            a_in[u] = '0; mode_in[u] = 2'b00;
        end
        #12;
        for (int u = 0; u < 2; u++) begin
            tests_run++;
            if (in_ready[u] !== 1'b1 || out_valid[u] !== 1'b0 || busy[u] !== 1'b0 || res[u] !== '0) begin
                tests_failed++;
                $display("FAIL reset_state u%0d: got rdy=%b ov=%b busy=%b res=%0d want 1/0/0/0",
                         u, in_ready[u], out_valid[u], busy[u], res[u]);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_spec_vectors();
        run_op(0, 8'b1011_0000, 2'b00, 0, "k1_ones_b0");
        run_op(1, 8'h0F,        2'b01, 0, "k2_zeros_0f");
        run_op(1, 8'h03,        2'b00, 0, "k2_ones_03");
        run_op(1, 8'b0010_0000, 2'b11, 0, "k2_tz_20");
        run_op(1, 8'b0001_0000, 2'b10, 0, "k2_lz_10");
        run_op(1, 8'h00,        2'b10, 0, "k2_lz_zero");
        run_op(1, 8'h00,        2'b11, 0, "k2_tz_zero");
        run_op(0, 8'h00,        2'b00, 0, "k1_ones_zero");
        run_op(0, 8'h80,        2'b10, 0, "k1_lz_msb");
        run_op(0, 8'h07,        2'b01, 0, "k1_par_07");
        run_op(1, 8'h03,        2'b11, 0, "k2_par_03");
    endtask

    task automatic test_hold();
        run_op(1, 8'h0F, 2'b01, 10, "k2_hold");
        run_op(0, 8'hA5, 2'b00, 10, "k1_hold");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_valid[1] = 1'b1; a_in[1] = 8'h03; mode_in[1] = 2'b00;
        @(posedge clk);
        #1;
        tests_run++;
        if (busy[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first_accept: got busy=%b want 1", busy[1]);
        end
        @(posedge clk);
        #1;
        out_ready[1] = 1'b1;
        tests_run++;
        if (out_valid[1] !== 1'b1 || res[1] !== 4'd2) begin
            tests_failed++;
            $display("FAIL b2b_first_result: got ov=%b res=%0d want 1/2", out_valid[1], res[1]);
        end
        @(posedge clk);
        #1;
        out_ready[1] = 1'b0;
        tests_run++;
        if (in_ready[1] !== 1'b1 || busy[1] !== 1'b0 || out_valid[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_no_same_cycle_accept: got rdy=%b busy=%b ov=%b want 1/0/0",
                     in_ready[1], busy[1], out_valid[1]);
        end
        a_in[1] = 8'h0C;
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        tests_run++;
        if (busy[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_second_accept: got busy=%b want 1", busy[1]);
        end
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (out_valid[1] !== 1'b1 || res[1] !== 4'd2) begin
            tests_failed++;
            $display("FAIL b2b_second_result: got ov=%b res=%0d want 1/2", out_valid[1], res[1]);
        end
        @(negedge clk);
        out_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[1] = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_valid[0] = 1'b1; a_in[0] = 8'hFF; mode_in[0] = 2'b00;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (busy[0] !== 1'b1 || res[0] !== 4'd3) begin
            tests_failed++;
            $display("FAIL areset_pre: got busy=%b res=%0d want 1/3", busy[0], res[0]);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || res[0] !== '0) begin
            tests_failed++;
            $display("FAIL areset_mid_run: got rdy=%b ov=%b busy=%b res=%0d want 1/0/0/0",
                     in_ready[0], out_valid[0], busy[0], res[0]);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_clear();
        bit saw_ov;
        @(negedge clk);
        in_valid[1] = 1'b1; a_in[1] = 8'h00; mode_in[1] = 2'b01;
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear[1] = 1'b1;
        @(posedge clk);
        #1;
        clear[1] = 1'b0;
        tests_run++;
        if (in_ready[1] !== 1'b1 || busy[1] !== 1'b0 || out_valid[1] !== 1'b0 || res[1] !== '0) begin
            tests_failed++;
            $display("FAIL clear_mid_run: got rdy=%b busy=%b ov=%b res=%0d want 1/0/0/0",
                     in_ready[1], busy[1], out_valid[1], res[1]);
        end
        saw_ov = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid[1] !== 1'b0) saw_ov = 1'b1;
        end
        tests_run++;
        if (saw_ov) begin
            tests_failed++;
            $display("FAIL clear_no_result: got out_valid=1 after clear want 0");
        end
        in_valid[1] = 1'b1; clear[1] = 1'b1; a_in[1] = 8'hFF;
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0; clear[1] = 1'b0;
        tests_run++;
        if (busy[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_priority: got busy=%b rdy=%b want 0/1", busy[1], in_ready[1]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_op($urandom_range(0, 1), N'($urandom), 2'($urandom_range(0, 3)),
                   $urandom_range(0, 2), "rand");
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_spec_vectors();
        test_hold();
        test_back_to_back();
        test_async_reset();
        test_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bit_counter.md
# bit_counter

Parametrised multi-cycle bit-statistics engine that accepts an N-bit operand over a valid/ready handshake and returns one of four counts: ones, zeros, leading zeros or trailing zeros. It examines K bits per clock and terminates early where the mode allows. It is the next-generation replacement for the single-mode, one-bit-per-cycle ones counter and sits between operand producers and result consumers in the lab datapath.

## Interface
- N, 8, operand width; N % K == 0 enforced by elaboration-time assertion
- K, 1, bits examined per RUN cycle (1 ≤ K ≤ N)
- RW, $clog2(N+1), result width (derived, not overridden)
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- clear  input  1  synchronous abort, returns to IDLE
- in_valid  input  1  operand offered
- in_ready  output  1  block can accept operand (state == IDLE)
- A  input  N  operand
- mode  input  2  00 ones, 01 zeros, 10 leading-zero, 11 trailing-zero
- out_valid  output  1  result held (state == DONE)
- out_ready  input  1  consumer takes result
- result  output  RW  count
- busy  output  1  state == RUN

## Operation
- States IDLE, RUN, DONE (Moore outputs only).
- IDLE: in_ready=1; on in_valid: load shift register (A, or bit-reversed A when mode=10), latch mode, clear result and chunk counter -> RUN.
- RUN: each cycle processes low K bits of shift register, shifts right by K, increments chunk counter.
  - ones: result += popcount(chunk); exit when shifted remainder == 0.
  - zeros: result += K - popcount(chunk); exit only after N/K chunks.
  - lz/tz: if chunk has a set bit, result += index of lowest set bit and exit; else result += K.
  - all modes: exit after chunk N/K regardless.
- DONE: out_valid=1, result stable; on out_ready -> IDLE.
- clear (any state) -> IDLE next edge, result cleared; clear has priority over every handshake.
- A == 0: ones -> result 0 after 1 RUN cycle; zeros/lz/tz -> result N.
- Result never exceeds N; RW bits always suffice.

## Timing
- Reset (async assert): state IDLE, result 0, in_ready 1, out_valid 0, busy 0.
- Accept edge: in_valid & in_ready. out_valid rises R cycles later, where R = RUN cycle count:
  - ones: max(1, ceil((p+1)/K)), p = highest set index.
  - zeros: N/K.
  - tz: ceil((t+1)/K), t = lowest set index; N/K if A == 0. lz: same on reversed operand.
- out_valid and result are held indefinitely until out_ready; the DONE->IDLE edge makes in_ready 1 on the next cycle (no same-cycle accept in DONE).
- Throughput: one operand per R+2 cycles minimum.

## Configuration
- BIT_COUNTER_PARITY_EN defined: adds output port parity (1 bit) = XOR of the operand latched at accept, valid while out_valid, reset 0, independent of mode.
- Undefined: port absent, no parity logic.

## Structure
- bit_counter_pkg: mode enum (MODE_ONES, MODE_ZEROS, MODE_LZ, MODE_TZ), state enum, helper function for RW.
- Sub-module bit_counter_chunk: combinational K-bit popcount plus lowest-set-index/found flag. Instantiated once; the top holds the FSM, shift register, chunk counter and accumulator.

## Test plan
- N=8,K=1, ones, A=8'b1011_0000 -> result 3, out_valid 8 cycles after accept (early exit at bit 7).
- N=8,K=2, zeros, A=8'h0F -> result 4 after exactly 4 RUN cycles; ones, A=8'h03 -> result 2 after 1 RUN cycle.
- N=8,K=2, tz A=8'b0010_0000 -> 5 (3 RUN cycles); lz A=8'b0001_0000 -> 3; lz/tz A=0 -> 8.
- out_ready held low 10 cycles in DONE -> result/out_valid stable, in_ready 0; back-to-back operands are accepted one cycle after the handshake.
- reset_n pulsed low mid-RUN (asynchronous, between edges) -> outputs reach reset values immediately; clear mid-RUN -> IDLE next edge, result 0, no out_valid.
- With BIT_COUNTER_PARITY_EN, A=8'h07 -> parity 1; A=8'h03 -> parity 0.
